mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage of the 5-stage MIPS core. It receives the EXE->MEM handshake and bus.
//  It waits for the data SRAM read data belonging to the load it holds, forms the final result,
//  and hands it to WB over the valid/allowin handshake.
//  It also exports dest/we/valid so ID can detect hazards.
// PARAMETERS
//  DSRAM_LAT  1  cycles from data SRAM request (issued in EXE cycle T) to rdata valid (cycle T+LAT); legal 1..3
// PORTS
//  clk              in   1    clock, all state on posedge
//  resetn           in   1    asynchronous, active-low reset
//  ws_allowin       in   1    WB can accept this cycle
//  ms_allowin       out  1    MEM can accept from EXE
//  es_to_ms_valid   in   1    EXE offers an instruction
//  es_to_ms_bus     in   71   {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
//  ms_to_ws_valid   out  1    MEM offers an instruction to WB
//  ms_to_ws_bus     out  70   {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
//  data_sram_rdata  in   32   data SRAM read data; valid only in cycle T+DSRAM_LAT
//  ms_waddr         out  5    dest of the held instruction
//  ms_wen           out  1    gr_we of the held instruction
//  ms_is_valid      out  1    ms_valid
// BEHAVIOUR
//  Reset values (async, resetn=0):
//   ms_valid=0, bus register=0, wait count=0, captured=0, rdata_r=0.
//   Hence ms_to_ws_valid=0, ms_allowin=1, ms_is_valid=0, ms_wen=0, ms_waddr=0.
//  Handshake:
//   - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
//   - ms_to_ws_valid = ms_valid && ms_ready_go.
//   - When ms_allowin=1, ms_valid <= es_to_ms_valid.
//   - When es_to_ms_valid && ms_allowin, the bus register <= es_to_ms_bus, cnt <= 0 and captured <= 0.
//  Load wait, for a held instruction with res_from_mem=1:
//   - The first MEM cycle is cycle T+1. rdata is valid when cnt == DSRAM_LAT-1.
//   - cnt increments each cycle while ms_valid && res_from_mem && !captured && cnt < DSRAM_LAT-1.
//   - In the arrival cycle (cnt == DSRAM_LAT-1 && !captured): rdata_r <= data_sram_rdata and captured <= 1.
//   - ms_ready_go = !res_from_mem || captured || (cnt == DSRAM_LAT-1).
//   - Loaded data = captured ? rdata_r : data_sram_rdata.
//     A WB stall after arrival therefore never loses data.
//  Non-load (ALU or store):
//   - ms_ready_go = 1 and final_result = alu_result.
//   - cnt and captured are ignored.
//  DSRAM_LAT=1: a load is ready in its first cycle, so there are zero bubbles at full throughput.
//  DSRAM_LAT=n: a load stalls n-1 cycles and EXE sees ms_allowin=0 during the stall.
//  Simultaneous leave and enter: the new instruction is loaded in the same edge, cnt and captured are
//   cleared, and the departing instruction's data has already been presented to WB.
//  ms_valid=0: ms_to_ws_valid=0. Bus and rdata contents are don't-care.
//   ms_wen and ms_waddr are still driven from the register, so ID must qualify them with ms_is_valid.
//  Reset mid-load: the instruction is dropped at once and no WB valid is produced.
//   rdata arriving after reset is ignored.
//  Width: all datapaths are 32 bit with no extension. Byte/half selection belongs to WB or a later lab.
// STRUCTURE
//  - mycpu.h (shared package) holds ES_TO_MS_BUS_WD=71, MS_TO_WS_BUS_WD=70 and the bus field offsets.
//  - One sub-module, ms_load_tracker: owns cnt, captured and rdata_r.
//    Inputs: accept, is_load, rdata.
//    Outputs: ready_go, load_data.
//  - The handshake and bus packing stay in mem_stage.
// TESTING
//  1. LAT=1: ALU instruction (alu_result=32'h1234, dest=5, gr_we=1) then a load whose rdata=32'hDEADBEEF
//     arrives in its first MEM cycle.
//     -> Two consecutive WB valids, final_result 32'h1234 then 32'hDEADBEEF, ms_allowin held at 1.
//  2. LAT=3, single load with rdata=32'hCAFE0001 at T+3.
//     -> ms_to_ws_valid=0 and ms_allowin=0 for 2 cycles, then valid with result 32'hCAFE0001.
//  3. LAT=1, load with ws_allowin=0 for 4 cycles; rdata is changed to 32'h0 after arrival.
//     -> Output stays 32'h55AA55AA (the captured value); the instruction leaves on the first ws_allowin=1.
//  4. Back-to-back loads with ws_allowin=1 every cycle, LAT=2.
//     -> Each load emits exactly one valid. The second load's cnt restarts at 0.
//     -> Results match the per-request rdata and no data from load 1 leaks into load 2.
//  5. resetn pulsed low mid-wait (LAT=3, after 1 cycle).
//     -> Outputs return to reset values asynchronously; no WB valid; ms_allowin=1 after release.
//  6. Store (gr_we=0, res_from_mem=0) followed by es_to_ms_valid=0.
//     -> One valid with gr_we=0, then ms_is_valid=0 and ms_to_ws_valid=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, field offsets
// and the packed layouts of the EXE->MEM and MEM->WB buses.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int MS_TO_WS_BUS_WD = 70;

    localparam int ES_PC_LSB       = 0;
    localparam int ES_ALU_LSB      = 32;
    localparam int ES_DEST_LSB     = 64;
    localparam int ES_GR_WE_BIT    = 69;
    localparam int ES_FROM_MEM_BIT = 70;

    localparam int LAT_CNT_W = 2;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_tracker.sv
// Load-wait tracker: counts cycles until the data SRAM answers and
// holds the returned word so a WB stall never loses it.
module ms_load_tracker
    import mem_stage_pkg::*;
#(
    parameter int DSRAM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        accept,
    input  logic        is_load,
    input  logic [31:0] rdata,
    output logic        ready_go,
    output logic [31:0] load_data
);

    localparam logic [LAT_CNT_W-1:0] LAST = LAT_CNT_W'(DSRAM_LAT - 1);

    logic [LAT_CNT_W-1:0] cnt;
    logic                 captured;
    logic [31:0]          rdata_r;
    logic                 arrive;

    assign arrive = is_load && !captured && (cnt == LAST);

    // Count wait cycles, latch rdata in its arrival cycle, clear on a new entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            captured <= 1'b0;
            rdata_r  <= '0;
        end else if (accept) begin
            cnt      <= '0;
            captured <= 1'b0;
        end else if (arrive) begin
            rdata_r  <= rdata;
            captured <= 1'b1;
        end else if (is_load && !captured) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ready_go  = !is_load || captured || (cnt == LAST);
    assign load_data = captured ? rdata_r : rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one EXE instruction, waits for its load
// data, and hands the final result to WB over valid/allowin.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DSRAM_LAT = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_waddr,
    output logic                       ms_wen,
    output logic                       ms_is_valid
);

    es_to_ms_t   ms_bus_r;
    ms_to_ws_t   ms_out;
    logic        ms_valid;
    logic        ms_ready_go;
    logic        accept;
    logic        is_load;
    logic [31:0] load_data;

    assign accept  = es_to_ms_valid && ms_allowin;
    assign is_load = ms_valid && ms_bus_r.res_from_mem;

    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Stage occupancy follows EXE whenever MEM can accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Capture the EXE bus only on a real handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_bus_r <= '0;
        end else if (accept) begin
            ms_bus_r <= es_to_ms_bus;
        end
    end

    ms_load_tracker #(
        .DSRAM_LAT (DSRAM_LAT)
    ) u_tracker (
        .clk       (clk),
        .resetn    (resetn),
        .accept    (accept),
        .is_load   (is_load),
        .rdata     (data_sram_rdata),
        .ready_go  (ms_ready_go),
        .load_data (load_data)
    );

    // Pack the WB bus; loads take memory data, everything else the ALU result.
    always_comb begin
        ms_out              = '0;
        ms_out.gr_we        = ms_bus_r.gr_we;
        ms_out.dest         = ms_bus_r.dest;
        ms_out.pc           = ms_bus_r.pc;
        ms_out.final_result = ms_bus_r.res_from_mem ? load_data
                                                    : ms_bus_r.alu_result;
    end

    assign ms_to_ws_bus = ms_out;
    assign ms_waddr     = ms_bus_r.dest;
    assign ms_wen       = ms_bus_r.gr_we;
    assign ms_is_valid  = ms_valid;

endmodule
